// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: PC register, variable-latency instruction memory handshake,
// one-word holding buffer for stalls, request kill on redirect, and the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          PCSrcE,
    input  logic [31:0]   PCTargetE,
    fetch_stage_if.master imem,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCD,
    output logic [31:0]   PCPlus4D,
    output logic          FetchBusyF
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4_q, pcplus4_d;

    logic        deliver;
    logic        ack;
    logic [31:0] pcf_plus4;
    logic        dlv_valid;
    logic [31:0] dlv_word;

    assign deliver   = !StallF && !StallD && !FlushD && !PCSrcE;
    assign ack       = imem.imem_ack;
    assign pcf_plus4 = pcf_q + 32'd4;

    // HOLD already owns a word, so no new request is issued until it is handed on.
    assign imem.imem_req  = resetn && (state_q != HOLD);
    assign imem.imem_addr = pcf_q;
    assign FetchBusyF     = imem.imem_req && !imem.imem_ack;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        hold_instr_d = hold_instr_q;
        redir_pc_d   = redir_pc_q;
        dlv_valid    = 1'b0;
        dlv_word     = hold_instr_q;

        unique case (state_q)
            FETCH: begin
                if (ack) begin
                    if (PCSrcE) begin
                        pcf_d = PCTargetE;
                    end else if (deliver) begin
                        dlv_valid = 1'b1;
                        dlv_word  = imem.imem_rdata;
                        pcf_d     = pcf_plus4;
                    end else begin
                        hold_instr_d = imem.imem_rdata;
                        state_d      = HOLD;
                    end
                end else if (PCSrcE) begin
                    // The in-flight request cannot be withdrawn; remember where to go.
                    redir_pc_d = PCTargetE;
                    state_d    = KILL;
                end
            end

            HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = FETCH;
                end else if (deliver) begin
                    dlv_valid = 1'b1;
                    dlv_word  = hold_instr_q;
                    pcf_d     = pcf_plus4;
                    state_d   = FETCH;
                end
            end

            KILL: begin
                if (PCSrcE) begin
                    redir_pc_d = PCTargetE;
                end
                if (ack) begin
                    pcf_d   = PCSrcE ? PCTargetE : redir_pc_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // IF/ID register: flush beats stall, stall beats delivery, otherwise a bubble.
    always_comb begin
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcplus4_d = pcplus4_q;

        if (FlushD) begin
            instr_d   = NOP_INSTR;
            pcd_d     = 32'd0;
            pcplus4_d = 32'd0;
        end else if (!StallD) begin
            if (dlv_valid) begin
                instr_d   = dlv_word;
                pcd_d     = pcf_q;
                pcplus4_d = pcf_plus4;
            end else begin
                instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= FETCH;
            pcf_q        <= RESET_PC;
            hold_instr_q <= 32'd0;
            redir_pc_q   <= 32'd0;
            instr_q      <= NOP_INSTR;
            pcd_q        <= 32'd0;
            pcplus4_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            hold_instr_q <= hold_instr_d;
            redir_pc_q   <= redir_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pcplus4_q    <= pcplus4_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcplus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized
// stalls/flushes/redirects/resets against a variable-latency memory and a transaction model.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        resetn;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        FetchBusyF;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem       (bus),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .FetchBusyF (FetchBusyF)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // Model: PC, an optional buffered word, an optional pending redirect whose
    // in-flight response must be swallowed, and the IF/ID contents.
    logic [31:0] m_pc, m_buf, m_redir, m_instr, m_pcd, m_pc4;
    logic        m_buf_v, m_kill;

    // Memory responder state
    int          mem_lat  = 0;
    int          mem_cnt  = 0;
    bit          mem_rand = 0;
    bit          word_inv = 0;
    int          busy_seen = 0;
    logic        last_req;
    logic [31:0] last_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of registered outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chkb("imem_req", bus.imem_req, resetn & ~m_buf_v);
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("InstrD", InstrD, m_instr);
            chk("PCD", PCD, m_pcd);
            chk("PCPlus4D", PCPlus4D, m_pc4);
        end
    end

    task automatic mem_respond();
        if (!resetn) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            mem_cnt        = 0;
            last_req       = 1'b0;
        end else if (bus.imem_req) begin
            last_req  = 1'b1;
            last_addr = bus.imem_addr;
            if (mem_cnt >= mem_lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = word_inv ? ~bus.imem_addr : bus.imem_addr;
                mem_cnt        = 0;
                if (mem_rand) mem_lat = $urandom_range(0, 3);
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                mem_cnt++;
            end
        end else begin
            last_req       = 1'b0;
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
        end
    endtask

    task automatic model_step();
        logic        req, ack, dlv_ok, have_word, delivered;
        logic [31:0] word, dpc;
        delivered = 1'b0;
        dpc       = 32'd0;
        word      = 32'd0;
        if (!resetn) begin
            m_pc    = RESET_PC;
            m_buf_v = 1'b0;
            m_kill  = 1'b0;
            m_buf   = 32'd0;
            m_redir = 32'd0;
            m_instr = NOP;
            m_pcd   = 32'd0;
            m_pc4   = 32'd0;
        end else begin
            req       = ~m_buf_v;
            ack       = bus.imem_ack & req;
            dlv_ok    = !StallF && !StallD && !FlushD && !PCSrcE;
            have_word = m_buf_v || (ack && !m_kill);
            word      = m_buf_v ? m_buf : bus.imem_rdata;
            if (PCSrcE) begin
                // A redirect applies at once unless a request is still unanswered.
                if (req && !ack) begin
                    m_kill  = 1'b1;
                    m_redir = PCTargetE;
                end else begin
                    m_pc    = PCTargetE;
                    m_kill  = 1'b0;
                    m_buf_v = 1'b0;
                end
            end else if (m_kill) begin
                if (ack) begin
                    m_pc   = m_redir;
                    m_kill = 1'b0;
                end
            end else if (have_word) begin
                if (dlv_ok) begin
                    delivered = 1'b1;
                    dpc       = m_pc;
                    m_pc      = m_pc + 32'd4;
                    m_buf_v   = 1'b0;
                end else begin
                    m_buf_v = 1'b1;
                    m_buf   = word;
                end
            end
            if (FlushD) begin
                m_instr = NOP;
                m_pcd   = 32'd0;
                m_pc4   = 32'd0;
            end else if (!StallD) begin
                if (delivered) begin
                    m_instr = word;
                    m_pcd   = dpc;
                    m_pc4   = dpc + 32'd4;
                end else begin
                    m_instr = NOP;
                end
            end
            if (delivered) $display("xfer pc=%08h instr=%08h", dpc, word);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, let memory respond,
    // advance the model, and return at the next falling edge.
    task automatic tick(input logic sf, input logic sd, input logic fl, input logic ps,
                        input logic [31:0] tgt, input logic rn);
        #1;
        StallF    = sf;
        StallD    = sd;
        FlushD    = fl;
        PCSrcE    = ps;
        PCTargetE = tgt;
        resetn    = rn;
        #1;
        mem_respond();
        #1;
        if (chk_en) chkb("FetchBusyF", FetchBusyF, resetn & ~m_buf_v & ~bus.imem_ack);
        if (FetchBusyF) busy_seen++;
        model_step();
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'd0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
        m_pc = RESET_PC; m_buf = 0; m_redir = 0; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
        m_buf_v = 1'b0; m_kill = 1'b0;
        last_req = 1'b0; last_addr = 32'd0;

        @(negedge clk);
        repeat (3) tick(0, 0, 0, 0, 32'd0, 0);
        chk_en = 1;

        // Reset state
        chk("rst_InstrD", InstrD, 32'h0000_0013);
        chk("rst_PCD", PCD, 32'd0);
        chk("rst_PCPlus4D", PCPlus4D, 32'd0);
        chkb("rst_req", bus.imem_req, 1'b0);
        chk("model_rst_instr", m_instr, 32'h0000_0013);

        // Zero-wait stream, rdata = addr
        mem_lat = 0; mem_cnt = 0;
        tick(0, 0, 0, 0, 32'd0, 1);
        chkb("first_req", last_req, 1'b1);
        chk("first_addr", last_addr, 32'h0000_0000);
        chk("zw_instr0", InstrD, 32'h0);
        chk("zw_pcd0", PCD, 32'h0);
        chk("zw_pc4_0", PCPlus4D, 32'h4);
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("zw_instr1", InstrD, 32'h4);
        chk("zw_pc4_1", PCPlus4D, 32'h8);
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("zw_instr2", InstrD, 32'h8);
        chk("model_zw_instr2", m_instr, 32'h8);
        chk("zw_addr", bus.imem_addr, 32'hC);

        // Three-cycle memory
        mem_lat = 2; busy_seen = 0;
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("lat_bubble0", InstrD, NOP);
        chk("lat_addr0", bus.imem_addr, 32'hC);
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("lat_bubble1", InstrD, NOP);
        chk("lat_addr1", bus.imem_addr, 32'hC);
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("lat_ack_addr", last_addr, 32'hC);
        chk("lat_instr", InstrD, 32'hC);
        chk("lat_busy_cycles", 32'(busy_seen), 32'd2);

        // Stall on the ack cycle at 0x10
        mem_lat = 0;
        tick(1, 1, 0, 0, 32'd0, 1);
        chkb("hold_req", bus.imem_req, 1'b0);
        chk("hold_instr_kept", InstrD, 32'hC);
        tick(1, 1, 0, 0, 32'd0, 1);
        chkb("hold_no_req", last_req, 1'b0);
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("hold_release_instr", InstrD, 32'h10);
        chk("hold_release_pcd", PCD, 32'h10);
        chk("hold_next_addr", bus.imem_addr, 32'h14);

        // Redirect while a request at 0x40 is outstanding
        tick(0, 0, 0, 1, 32'h40, 1);
        chk("redir_addr40", bus.imem_addr, 32'h40);
        mem_lat = 2;
        tick(0, 0, 0, 1, 32'h200, 1);
        chk("kill_addr0", bus.imem_addr, 32'h40);
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("kill_addr1", bus.imem_addr, 32'h40);
        chk("kill_instr1", InstrD, NOP);
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("kill_next_addr", bus.imem_addr, 32'h200);
        chk("kill_instr2", InstrD, NOP);

        // PC wrap, then reset mid-wait
        mem_lat = 0;
        tick(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4D, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        tick(0, 0, 0, 1, 32'h300, 1);
        mem_lat = 2;
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("wait_addr300", bus.imem_addr, 32'h300);
        tick(0, 0, 0, 0, 32'd0, 0);
        chk("midrst_instr", InstrD, NOP);
        chk("midrst_pcd", PCD, 32'd0);
        chk("midrst_pc4", PCPlus4D, 32'd0);
        chk("midrst_addr", bus.imem_addr, RESET_PC);
        mem_lat = 0;
        tick(0, 0, 0, 0, 32'd0, 1);
        chk("restart_addr", last_addr, RESET_PC);
        chk("restart_instr", InstrD, RESET_PC);

        // Randomized traffic
        word_inv = 1; mem_rand = 1; mem_lat = $urandom_range(0, 3);
        for (int i = 0; i < 2000; i++) begin
            logic        sf, sd, fl, ps, rn;
            logic [31:0] tgt;
            sf  = ($urandom_range(0, 3) == 0);
            sd  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            ps  = ($urandom_range(0, 7) == 0);
            rn  = ($urandom_range(0, 99) != 0);
            tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF);
            tick(sf, sd, fl, ps, tgt, rn);
        end

        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
